// File: rtl/imm_pkg.sv
// Immediate-format select codes shared by the decode-stage immediate generator
// and the control decoder that drives imm_src.
package imm_pkg;

    localparam int IMM_SRC_W = 3;

    localparam logic [IMM_SRC_W-1:0] IMM_I     = 3'b000;
    localparam logic [IMM_SRC_W-1:0] IMM_S     = 3'b001;
    localparam logic [IMM_SRC_W-1:0] IMM_B     = 3'b010;
    localparam logic [IMM_SRC_W-1:0] IMM_U     = 3'b011;
    localparam logic [IMM_SRC_W-1:0] IMM_J     = 3'b100;
    localparam logic [IMM_SRC_W-1:0] IMM_SHAMT = 3'b101;
    localparam logic [IMM_SRC_W-1:0] IMM_ZIMM  = 3'b110;
    localparam logic [IMM_SRC_W-1:0] IMM_ZERO  = 3'b111;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: slices the RV32I/RV64I instruction word
// according to imm_src and sign- or zero-extends the result to XLEN.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]          instr,
    input  logic [IMM_SRC_W-1:0] imm_src,
    output logic [XLEN-1:0]      imm
);

    logic        sign;
    logic [5:0]  shamt;
    logic        unused_opcode;

    assign sign          = instr[31];
    assign unused_opcode = ^instr[6:0];

    // RV64 shift amounts use one extra instruction bit
    assign shamt = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};

    always_comb begin
        imm = '0;
        case (imm_src)
            IMM_I:     imm = {{(XLEN-12){sign}}, instr[31:20]};
            IMM_S:     imm = {{(XLEN-12){sign}}, instr[31:25], instr[11:7]};
            IMM_B:     imm = {{(XLEN-13){sign}}, instr[31], instr[7],
                              instr[30:25], instr[11:8], 1'b0};
            IMM_U:     imm = {{(XLEN-32){sign}}, instr[31:12], 12'b0};
            IMM_J:     imm = {{(XLEN-21){sign}}, instr[31], instr[19:12],
                              instr[20], instr[30:21], 1'b0};
            IMM_SHAMT: imm = {{(XLEN-6){1'b0}}, shamt};
            IMM_ZIMM:  imm = {{(XLEN-5){1'b0}}, instr[19:15]};
            default:   imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: extracts the immediate, then buffers it with
// its tag in a 2-entry (main + skid) valid/ready stage with synchronous flush.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [IMM_SRC_W-1:0] imm_src,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_imm,
    output logic [TAG_W-1:0]     out_tag
);

    logic [XLEN-1:0]  ext_imm;

    logic             main_valid;
    logic [XLEN-1:0]  main_imm;
    logic [TAG_W-1:0] main_tag;

    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;

    logic             take_in;
    logic             main_free;

    imm_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .instr   (instr),
        .imm_src (imm_src),
        .imm     (ext_imm)
    );

    // in_ready depends only on state so upstream never sees a combinational loop
    assign in_ready  = !skid_valid;
    assign take_in   = in_valid && in_ready && !flush;
    assign main_free = !main_valid || out_ready;

    assign out_valid = main_valid;
    assign out_imm   = main_imm;
    assign out_tag   = main_tag;

    // Valid flags; flush clears both entries but leaves the data registers alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= take_in;
            end
        end else if (take_in) begin
            skid_valid <= 1'b1;
        end
    end

    // Data path: skid has priority into main so ordering stays FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_imm <= '0;
            main_tag <= '0;
            skid_imm <= '0;
            skid_tag <= '0;
        end else if (!flush) begin
            if (main_free) begin
                if (skid_valid) begin
                    main_imm <= skid_imm;
                    main_tag <= skid_tag;
                end else if (take_in) begin
                    main_imm <= ext_imm;
                    main_tag <= in_tag;
                end
            end else if (take_in) begin
                skid_imm <= ext_imm;
                skid_tag <= in_tag;
            end
        end
    end

endmodule
